// File: rtl/jzjpcc_fetch_sequencer.sv
// jzjpcc_fetch_sequencer
// Fetch-stage PC control. Arbitrates redirect requests (trap > pending >
// execute > decode) and drives the PC's stall_fetch, pcCTWriteEnable and
// controlTransferNewPC inputs. Generates fetch/decode flushes. Sequences
// boot, instruction-memory wait states and debug halt.
//
// Handshake: a redirect is "selected" whenever pcCTWriteEnable=1. It is
// "accepted" at a rising edge where it is selected and stall_fetch=0. Only
// accepted redirects flush. A new request that is selected but not accepted
// is held in a one-entry pending register until it is accepted. A trap can
// also overwrite the held entry.
//
// Optional feature: define JZJPCC_FETCH_PERF_EN to add the redirect_count
// and stall_count performance counters.

module jzjpcc_fetch_sequencer #(
    // Word address [31:2] loaded on a trap (byte address 32'h4).
    parameter logic [29:0] TRAP_VECTOR = 30'h00000001,
    // Edges stall_fetch is held after reset release; legal range 1..15.
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    input  logic        trap_valid,
    input  logic        exec_redirect_valid,
    input  logic [29:0] exec_redirect_pc,
    input  logic        dec_redirect_valid,
    input  logic [29:0] dec_redirect_pc,
    input  logic        halt_req,
    output logic        stall_fetch,
    output logic        pcCTWriteEnable,
    output logic [29:0] controlTransferNewPC,
    output logic        flush_fetch,
    output logic        flush_decode,
`ifdef JZJPCC_FETCH_PERF_EN
    output logic [31:0] redirect_count,
    output logic [31:0] stall_count,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Source of the currently selected redirect.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_TRAP = 3'd1,
        SRC_PEND = 3'd2,
        SRC_EXEC = 3'd3,
        SRC_DEC  = 3'd4
    } src_e;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic        pend_valid_q, pend_valid_d;
    logic [29:0] pend_pc_q, pend_pc_d;
    // Set when the held entry must also flush decode (it came from trap/exec).
    logic        pend_fd_q, pend_fd_d;

    src_e        sel_src;
    logic [29:0] sel_pc;
    logic        sel_fd;
    logic        sel_is_new;
    logic        new_req;
    logic        accept;

    // Any fresh request this cycle, regardless of state.
    assign new_req = trap_valid | exec_redirect_valid | dec_redirect_valid;

    // Priority select among trap, pending entry, execute and decode.
    always_comb begin
        sel_src = SRC_NONE;
        sel_pc  = '0;
        sel_fd  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (trap_valid) begin
                    sel_src = SRC_TRAP;
                    sel_pc  = TRAP_VECTOR;
                    sel_fd  = 1'b1;
                end else if (pend_valid_q) begin
                    sel_src = SRC_PEND;
                    sel_pc  = pend_pc_q;
                    sel_fd  = pend_fd_q;
                end else if (exec_redirect_valid) begin
                    sel_src = SRC_EXEC;
                    sel_pc  = exec_redirect_pc;
                    sel_fd  = 1'b1;
                end else if (dec_redirect_valid) begin
                    sel_src = SRC_DEC;
                    sel_pc  = dec_redirect_pc;
                    sel_fd  = 1'b0;
                end
            end
            ST_HALT: begin
                // While halted only a trap (or an entry it left behind) counts.
                if (trap_valid) begin
                    sel_src = SRC_TRAP;
                    sel_pc  = TRAP_VECTOR;
                    sel_fd  = 1'b1;
                end else if (pend_valid_q) begin
                    sel_src = SRC_PEND;
                    sel_pc  = pend_pc_q;
                    sel_fd  = pend_fd_q;
                end
            end
            default: begin
                sel_src = SRC_NONE;
            end
        endcase
    end

    assign sel_is_new = (sel_src == SRC_TRAP) | (sel_src == SRC_EXEC) |
                        (sel_src == SRC_DEC);

    // Stall generation and PC/flush outputs.
    always_comb begin
        stall_fetch          = 1'b1;
        pcCTWriteEnable      = 1'b0;
        controlTransferNewPC = '0;
        flush_fetch          = 1'b0;
        flush_decode         = 1'b0;
        halted               = 1'b0;
        accept               = 1'b0;

        if (state_q == ST_RUN) begin
            // Halt only stalls once nothing is left to redirect.
            stall_fetch = hazard_stall | ~imem_ready |
                          (halt_req & ~pend_valid_q & ~new_req);
        end
        if (state_q == ST_HALT) begin
            halted = 1'b1;
        end

        if (sel_src != SRC_NONE) begin
            pcCTWriteEnable      = 1'b1;
            controlTransferNewPC = sel_pc;
        end

        accept       = (sel_src != SRC_NONE) & ~stall_fetch;
        flush_fetch  = accept;
        flush_decode = accept & sel_fd;
    end

    // Next-state: boot counting, pending capture/clear, halt entry/exit.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_fd_d    = pend_fd_q;

        unique case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HALT: begin
                if (accept) begin
                    pend_valid_d = 1'b0;
                end else if (sel_is_new && stall_fetch) begin
                    // Hold the selected request; a trap overwrites any entry.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = sel_pc;
                    pend_fd_d    = sel_fd;
                end

                if (state_q == ST_RUN) begin
                    if (halt_req && !pend_valid_q && !new_req) begin
                        state_d = ST_HALT;
                    end
                end else if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and pending register; reset discards everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            boot_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            pend_fd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_fd_q    <= pend_fd_d;
        end
    end

`ifdef JZJPCC_FETCH_PERF_EN
    logic [31:0] redirect_count_q, redirect_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;
        if (accept) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
        if ((state_q == ST_RUN) && stall_fetch) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
    assign stall_count    = stall_count_q;
`endif

endmodule

// File: tb/tb_jzjpcc_fetch_sequencer.sv
// Testbench for jzjpcc_fetch_sequencer: directed vectors with literal
// expectations, plus a per-cycle comparison against a priority-table model.
`timescale 1ns/1ps

module tb_jzjpcc_fetch_sequencer;

    localparam logic [29:0] TV = 30'h00000001;
    localparam int BC = 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        hazard_stall, imem_ready, trap_valid;
    logic        exec_redirect_valid, dec_redirect_valid, halt_req;
    logic [29:0] exec_redirect_pc, dec_redirect_pc;
    logic        stall_fetch, pcCTWriteEnable, flush_fetch, flush_decode, halted;
    logic [29:0] controlTransferNewPC;
`ifdef JZJPCC_FETCH_PERF_EN
    logic [31:0] redirect_count, stall_count;
`endif

    jzjpcc_fetch_sequencer #(.TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
        .clock(clock),
        .reset(reset),
        .hazard_stall(hazard_stall),
        .imem_ready(imem_ready),
        .trap_valid(trap_valid),
        .exec_redirect_valid(exec_redirect_valid),
        .exec_redirect_pc(exec_redirect_pc),
        .dec_redirect_valid(dec_redirect_valid),
        .dec_redirect_pc(dec_redirect_pc),
        .halt_req(halt_req),
        .stall_fetch(stall_fetch),
        .pcCTWriteEnable(pcCTWriteEnable),
        .controlTransferNewPC(controlTransferNewPC),
        .flush_fetch(flush_fetch),
        .flush_decode(flush_decode),
`ifdef JZJPCC_FETCH_PERF_EN
        .redirect_count(redirect_count),
        .stall_count(stall_count),
`endif
        .halted(halted)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int          m_state = M_BOOT;
    int          m_boot = 0;
    bit          m_pv = 0;
    logic [29:0] m_ppc = '0;
    bit          m_pfd = 0;
    int unsigned m_redir = 0, m_stalls = 0;

    // Candidate table in priority order: trap, pending, exec, dec.
    bit          c_ok[4];
    logic [29:0] c_pc[4];
    bit          c_fd[4];
    bit          c_new[4];

    bit          e_stall, e_we, e_ff, e_fd, e_halted, e_acc, e_newreq;
    logic [29:0] e_pc;
    int          e_sel;

    task automatic model_reset();
        m_state = M_BOOT; m_boot = 0; m_pv = 0; m_ppc = '0; m_pfd = 0;
        m_redir = 0; m_stalls = 0;
    endtask

    task automatic model_outputs();
        e_stall = 1; e_we = 0; e_pc = '0; e_ff = 0; e_fd = 0; e_halted = 0;
        e_acc = 0; e_sel = -1;
        e_newreq = trap_valid | exec_redirect_valid | dec_redirect_valid;
        if (reset) begin
            model_reset();
            return;
        end
        c_ok[0] = (m_state != M_BOOT) && trap_valid; c_pc[0] = TV; c_fd[0] = 1; c_new[0] = 1;
        c_ok[1] = (m_state != M_BOOT) && m_pv; c_pc[1] = m_ppc; c_fd[1] = m_pfd; c_new[1] = 0;
        c_ok[2] = (m_state == M_RUN) && exec_redirect_valid; c_pc[2] = exec_redirect_pc;
        c_fd[2] = 1; c_new[2] = 1;
        c_ok[3] = (m_state == M_RUN) && dec_redirect_valid; c_pc[3] = dec_redirect_pc;
        c_fd[3] = 0; c_new[3] = 1;
        for (int i = 0; i < 4; i++) if (c_ok[i] && e_sel < 0) e_sel = i;
        if (m_state == M_RUN)
            e_stall = hazard_stall | !imem_ready | (halt_req & !m_pv & !e_newreq);
        e_halted = (m_state == M_HALT);
        if (e_sel >= 0) begin
            e_we = 1;
            e_pc = c_pc[e_sel];
            e_acc = !e_stall;
            e_ff = e_acc;
            e_fd = e_acc & c_fd[e_sel];
        end
    endtask

    task automatic model_advance();
        bit old_pv;
        if (reset) begin
            model_reset();
            return;
        end
        old_pv = m_pv;
        if (m_state == M_BOOT) begin
            m_boot++;
            if (m_boot >= BC) m_state = M_RUN;
            return;
        end
        if (e_acc) begin
            m_pv = 0;
            m_redir++;
        end else if (e_sel >= 0 && c_new[e_sel] && e_stall) begin
            m_pv = 1; m_ppc = c_pc[e_sel]; m_pfd = c_fd[e_sel];
        end
        if (m_state == M_RUN) begin
            if (e_stall) m_stalls++;
            if (halt_req && !old_pv && !e_newreq) m_state = M_HALT;
        end else if (!halt_req) begin
            m_state = M_RUN;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin : compare
        forever begin
            @(negedge clock);
            model_outputs();
            chk("cmp_stall_fetch", 32'(stall_fetch), 32'(e_stall));
            chk("cmp_we", 32'(pcCTWriteEnable), 32'(e_we));
            chk("cmp_new_pc", 32'(controlTransferNewPC), 32'(e_pc));
            chk("cmp_flush_fetch", 32'(flush_fetch), 32'(e_ff));
            chk("cmp_flush_decode", 32'(flush_decode), 32'(e_fd));
            chk("cmp_halted", 32'(halted), 32'(e_halted));
`ifdef JZJPCC_FETCH_PERF_EN
            chk("cmp_redirect_count", redirect_count, m_redir);
            chk("cmp_stall_count", stall_count, m_stalls);
`endif
            @(posedge clock);
            model_advance();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic set_in(input bit tr, input bit ev, input logic [29:0] epc,
                          input bit dv, input logic [29:0] dpc,
                          input bit hz, input bit im, input bit hr);
        trap_valid = tr;
        exec_redirect_valid = ev; exec_redirect_pc = epc;
        dec_redirect_valid = dv; dec_redirect_pc = dpc;
        hazard_stall = hz; imem_ready = im; halt_req = hr;
    endtask

    // Watchdog: the directed sequence is fixed length, so this is only a guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        repeat (3) tick();
        sample();
        chk("reset_stall", 32'(stall_fetch), 32'd1);
        chk("reset_we", 32'(pcCTWriteEnable), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;

        // Boot: one stalled cycle, then running with no redirect.
        sample();
        chk("boot_stall", 32'(stall_fetch), 32'd1);
        tick();
        sample();
        chk("run_stall", 32'(stall_fetch), 32'd0);
        chk("run_we", 32'(pcCTWriteEnable), 32'd0);
        tick();

        // Execute redirect accepted in the same cycle.
        set_in(0, 1, 30'h40, 0, '0, 0, 1, 0);
        sample();
        chk("exec_we", 32'(pcCTWriteEnable), 32'd1);
        chk("exec_pc", 32'(controlTransferNewPC), 32'h40);
        chk("exec_ff", 32'(flush_fetch), 32'd1);
        chk("exec_fd", 32'(flush_decode), 32'd1);
        tick();

        // Decode redirect held during imem wait, then wins over a new exec.
        set_in(0, 0, '0, 1, 30'h10, 0, 0, 0);
        sample();
        chk("dec_wait_stall", 32'(stall_fetch), 32'd1);
        chk("dec_wait_ff", 32'(flush_fetch), 32'd0);
        tick();
        set_in(0, 1, 30'h20, 0, '0, 0, 1, 0);
        sample();
        chk("pend_pc", 32'(controlTransferNewPC), 32'h10);
        chk("pend_ff", 32'(flush_fetch), 32'd1);
        chk("pend_fd", 32'(flush_decode), 32'd0);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        sample();
        chk("exec_dropped_we", 32'(pcCTWriteEnable), 32'd0);
        tick();

        // Trap + exec + dec together, unstalled.
        set_in(1, 1, 30'h21, 1, 30'h22, 0, 1, 0);
        sample();
        chk("trap_pc", 32'(controlTransferNewPC), 32'(TV));
        chk("trap_ff", 32'(flush_fetch), 32'd1);
        chk("trap_fd", 32'(flush_decode), 32'd1);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        sample();
        chk("trap_no_pend", 32'(pcCTWriteEnable), 32'd0);
        tick();

        // Trap replaces a pending exec while stalled by a hazard.
        set_in(0, 1, 30'h33, 0, '0, 1, 1, 0);
        sample();
        chk("hz_stall", 32'(stall_fetch), 32'd1);
        chk("hz_pc", 32'(controlTransferNewPC), 32'h33);
        tick();
        set_in(1, 0, '0, 0, '0, 1, 1, 0);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        sample();
        chk("replace_pc", 32'(controlTransferNewPC), 32'(TV));
        chk("replace_fd", 32'(flush_decode), 32'd1);
        tick();

        // Halt, trap captured while halted, accepted after release.
        set_in(0, 0, '0, 0, '0, 0, 1, 1);
        sample();
        chk("halt_req_stall", 32'(stall_fetch), 32'd1);
        chk("halt_req_halted", 32'(halted), 32'd0);
        tick();
        set_in(0, 0, '0, 1, 30'h44, 0, 1, 1);
        sample();
        chk("halted", 32'(halted), 32'd1);
        chk("halt_dec_ignored", 32'(pcCTWriteEnable), 32'd0);
        tick();
        set_in(1, 0, '0, 0, '0, 0, 1, 1);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        sample();
        chk("halt_pend_pc", 32'(controlTransferNewPC), 32'(TV));
        chk("halt_pend_ff", 32'(flush_fetch), 32'd0);
        tick();
        sample();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_ff", 32'(flush_fetch), 32'd1);
        chk("unhalt_fd", 32'(flush_decode), 32'd1);
        tick();

        // A pending entry completes before halt takes effect.
        set_in(0, 0, '0, 1, 30'h55, 0, 0, 0);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 1);
        sample();
        chk("halt_after_pend_stall", 32'(stall_fetch), 32'd0);
        chk("halt_after_pend_pc", 32'(controlTransferNewPC), 32'h55);
        tick();
        sample();
        chk("halt_after_pend_stall2", 32'(stall_fetch), 32'd1);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        tick();

        // Reset while an entry is pending.
        set_in(0, 1, 30'h77, 0, '0, 0, 0, 0);
        tick();
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        reset = 1'b1;
        sample();
        chk("mid_reset_we", 32'(pcCTWriteEnable), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        sample();
        chk("post_reset_we", 32'(pcCTWriteEnable), 32'd0);
        chk("post_reset_stall", 32'(stall_fetch), 32'd0);
`ifdef JZJPCC_FETCH_PERF_EN
        chk("post_reset_redirect_count", redirect_count, 32'd0);
`endif
        tick();

        // Randomised traffic, checked only by the compare process.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0, 30'($urandom),
                   $urandom_range(0, 3) == 0, 30'($urandom),
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 4) != 0,
                   $urandom_range(0, 7) == 0);
            tick();
        end
        set_in(0, 0, '0, 0, '0, 0, 1, 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
